// File: rtl/canvas_streamer.sv
// Streams a DIM x DIM canvas out one pixel per beat in row-major order over valid/ready.
// A rising edge on Start launches one frame, and Done pulses once the final beat is accepted.
module canvas_streamer #(
  parameter int DIM   = 28,
  parameter int PIX_W = 16,
  parameter int IDX_W = 10
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic                                 Start,
  input  logic [DIM-1:0][DIM-1:0][PIX_W-1:0]   canvas,
  output logic [PIX_W-1:0]                     Pix_Data,
  output logic [IDX_W-1:0]                     Pix_Index,
  output logic                                 Pix_Valid,
  input  logic                                 Pix_Ready,
  output logic                                 Pix_Last,
  output logic                                 Busy,
  output logic                                 Done
);
  localparam int RC_W = (DIM > 1) ? $clog2(DIM) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_q;
  logic              start_q;
  logic [RC_W-1:0]   row_q, col_q, row_d, col_d;
  logic [PIX_W-1:0]  data_q;
  logic [IDX_W-1:0]  idx_q;
  logic              valid_q, last_q, busy_q, done_q, last_d;
  logic              start_edge;

  assign start_edge = Start & ~start_q;

  // row/col always point at the pixel currently presented on the bus
  always_comb begin
    row_d = row_q;
    col_d = col_q + 1'b1;
    if (col_q == RC_W'(DIM-1)) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end
    last_d = (row_d == RC_W'(DIM-1)) && (col_d == RC_W'(DIM-1));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= Start;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            state_q <= STREAM;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            data_q  <= canvas[0][0];
            last_q  <= (DIM == 1);
          end
        end
        STREAM: begin
          if (valid_q && Pix_Ready) begin
            if (last_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              row_q   <= '0;
              col_q   <= '0;
              idx_q   <= '0;
            end else begin
              // canvas is sampled live here, so edits ahead of the scan show up
              row_q   <= row_d;
              col_q   <= col_d;
              idx_q   <= idx_q + 1'b1;
              data_q  <= canvas[row_d][col_d];
              last_q  <= last_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Pix_Data  = data_q;
  assign Pix_Index = idx_q;
  assign Pix_Valid = valid_q;
  assign Pix_Last  = last_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
endmodule

// File: tb/tb_canvas_streamer.sv
// Bench for canvas_streamer: scoreboard of expected beats plus frame table and corner sequences.
module tb_canvas_streamer;
  localparam int DIM = 28, PIX_W = 16, IDX_W = 10, NPIX = DIM*DIM;

  typedef struct {
    logic [PIX_W-1:0] d;
    logic [IDX_W-1:0] i;
    logic             l;
  } beat_t;
  typedef struct {
    string name;
    int    pattern;
    int    bp_pct;
    bit    check_span;
  } frame_vec_t;
  typedef struct {
    int               idx;
    logic [PIX_W-1:0] exp;
  } spot_t;

  logic                               Clk = 0, Reset = 1, Start = 0, Pix_Ready = 0;
  logic [DIM-1:0][DIM-1:0][PIX_W-1:0] canvas = '0;
  logic [PIX_W-1:0]                   Pix_Data;
  logic [IDX_W-1:0]                   Pix_Index;
  logic                               Pix_Valid, Pix_Last, Busy, Done;

  canvas_streamer #(.DIM(DIM), .PIX_W(PIX_W), .IDX_W(IDX_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .canvas(canvas),
    .Pix_Data(Pix_Data), .Pix_Index(Pix_Index), .Pix_Valid(Pix_Valid),
    .Pix_Ready(Pix_Ready), .Pix_Last(Pix_Last), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0, n_fail = 0;
  beat_t exp_q[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int bp_pct = 0;
  always @(posedge Clk) begin
    #1;
    Pix_Ready = (bp_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= bp_pct);
  end

  // Monitor: scoreboard pops on accepted beats, held beats must stay stable
  int   cyc = 0, beats = 0, done_cnt = 0, first_cyc = 0, last_cyc = 0;
  logic hold = 0, last_acc = 0;
  beat_t held;
  logic [PIX_W-1:0] seen [1024];

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (Reset) begin
      hold = 0;
      last_acc = 0;
    end else begin
      if (hold && Pix_Valid)
        check("hold_stable", 64'({Pix_Data, Pix_Index, Pix_Last}), 64'({held.d, held.i, held.l}));
      if (last_acc || Done) check("done_pulse", 64'(Done), 64'(last_acc));
      if (Done) done_cnt++;
      check("busy_vs_valid", 64'(Busy), 64'(Pix_Valid));
      last_acc = 0;
      hold = 0;
      if (Pix_Valid && Pix_Ready) begin
        check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat", 64'({Pix_Data, Pix_Index, Pix_Last}), 64'({e.d, e.i, e.l}));
        end
        seen[Pix_Index] = Pix_Data;
        beats++;
        if (Pix_Index == 0) first_cyc = cyc;
        last_cyc = cyc;
        last_acc = Pix_Last;
      end else if (Pix_Valid) begin
        hold = 1;
        held = '{Pix_Data, Pix_Index, Pix_Last};
      end
    end
  end

  task automatic fill(int pattern);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        case (pattern)
          0:       canvas[r][c] = PIX_W'(r*DIM + c);
          1:       canvas[r][c] = PIX_W'($urandom);
          default: canvas[r][c] = '0;
        endcase
  endtask

  task automatic push_frame();
    for (int k = 0; k < NPIX; k++)
      exp_q.push_back('{canvas[k/DIM][k%DIM], IDX_W'(k), k == NPIX-1});
  endtask

  task automatic pulse_start();
    @(posedge Clk); #1 Start = 1;
    @(posedge Clk); #1 Start = 0;
  endtask

  task automatic wait_done(string name, int target, int maxc);
    int k = 0;
    while (done_cnt < target && k < maxc) begin
      @(negedge Clk);
      k++;
    end
    check(name, 64'(done_cnt), 64'(target));
  endtask

  frame_vec_t fv[3];
  spot_t      sp[3];

  initial begin
    int d0, b0, k;
    fv[0] = '{"basic", 0, 0, 1};
    fv[1] = '{"bp50", 0, 50, 0};
    fv[2] = '{"rand_bp30", 1, 30, 0};
    sp[0] = '{27, 16'h0};
    sp[1] = '{28, 16'hBEEF};
    sp[2] = '{29, 16'h0};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_outputs", 64'({Pix_Data, Pix_Index, Pix_Valid, Pix_Last, Busy, Done}), 64'd0);
    @(posedge Clk); #1 Reset = 0;

    // frame table: patterns with and without backpressure
    foreach (fv[i]) begin
      bp_pct = fv[i].bp_pct;
      fill(fv[i].pattern);
      push_frame();
      d0 = done_cnt;
      b0 = beats;
      pulse_start();
      wait_done({fv[i].name, "_done"}, d0 + 1, 6000);
      check({fv[i].name, "_beats"}, 64'(beats - b0), 64'(NPIX));
      check({fv[i].name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
      @(negedge Clk);
      check({fv[i].name, "_busy_after"}, 64'(Busy), 64'd0);
      if (fv[i].check_span)
        check({fv[i].name, "_span"}, 64'(last_cyc - first_cyc), 64'(NPIX - 1));
    end
    bp_pct = 0;

    // Start held long with a second edge mid-frame: exactly one frame
    fill(0);
    push_frame();
    d0 = done_cnt;
    b0 = beats;
    @(posedge Clk); #1 Start = 1;
    k = 0;
    while (beats - b0 < 100 && k < 2000) begin
      @(negedge Clk);
      k++;
    end
    Start = 0;
    @(negedge Clk);
    Start = 1;
    repeat (900) @(negedge Clk);
    Start = 0;
    check("held_start_frames", 64'(done_cnt - d0), 64'd1);
    check("held_start_beats", 64'(beats - b0), 64'(NPIX));
    check("held_start_sb_empty", 64'(exp_q.size()), 64'd0);

    // edge in the Done cycle starts a new frame immediately
    push_frame();
    push_frame();
    d0 = done_cnt;
    pulse_start();
    k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!Done && k < 3000);
    check("done_seen", 64'(Done), 64'd1);
    Start = 1;
    @(posedge Clk); #1 Start = 0;
    @(negedge Clk);
    check("restart_idx0", 64'({Pix_Valid, Pix_Index}), 64'({1'b1, IDX_W'(0)}));
    wait_done("restart_done", d0 + 2, 3000);
    check("restart_sb_empty", 64'(exp_q.size()), 64'd0);

    // reset mid-frame at index 400
    push_frame();
    d0 = done_cnt;
    pulse_start();
    k = 0;
    do begin
      @(posedge Clk); #1;
      k++;
    end while (!(Pix_Valid && Pix_Index == 400) && k < 3000);
    check("reached_400", 64'(Pix_Index), 64'd400);
    Reset = 1;
    @(posedge Clk); #1 Reset = 0;
    @(negedge Clk);
    check("midreset_outputs", 64'({Pix_Data, Pix_Index, Pix_Valid, Pix_Last, Busy, Done}), 64'd0);
    exp_q.delete();
    repeat (900) @(negedge Clk);
    check("midreset_no_done", 64'(done_cnt), 64'(d0));
    push_frame();
    pulse_start();
    wait_done("post_reset_done", d0 + 1, 3000);
    check("post_reset_sb_empty", 64'(exp_q.size()), 64'd0);

    // row wrap: single marker pixel at row 1, col 0
    fill(2);
    canvas[1][0] = 16'hBEEF;
    push_frame();
    d0 = done_cnt;
    pulse_start();
    wait_done("wrap_done", d0 + 1, 3000);
    foreach (sp[i])
      check($sformatf("wrap_idx%0d", sp[i].idx), 64'(seen[sp[i].idx]), 64'(sp[i].exp));

    // live edit of the last pixel while the scan is at index 10
    fill(0);
    push_frame();
    exp_q[NPIX-1].d = 16'h1234;
    d0 = done_cnt;
    pulse_start();
    k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (!(Pix_Valid && Pix_Index == 10) && k < 3000);
    canvas[DIM-1][DIM-1] = 16'h1234;
    wait_done("live_done", d0 + 1, 3000);
    check("live_last_pixel", 64'(seen[NPIX-1]), 64'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
